store_drain_buffer: RTL and testbench

STORE_DRAIN_BUFFER -- requirements
Module: store_drain_buffer

---
 rtl/store_drain_buffer.sv | 124 ++++++++++++
 tb/tb_store_drain_buffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// Committed-store buffer that drains stores to the dcache in two phases:
// an index phase (request/grant) followed one cycle later by the tag phase.
module store_drain_buffer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned INDEX_W = 12,
    parameter int unsigned TAG_W   = 44
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    // Handshakes: a transfer happens on a rising clk_i edge where valid and
    // ready are both high. The receiver of a valid never waits on it: ready
    // does not depend on valid. data_req_o plays the valid role towards the
    // dcache, and data_gnt_i plays the ready role.
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [INDEX_W+TAG_W-1:0]     push_paddr_i,
    input  logic [63:0]                  push_data_i,
    input  logic [7:0]                   push_be_i,
    input  logic [1:0]                   push_size_i,
    input  logic [INDEX_W-1:0]           page_offset_i,
    output logic                         page_offset_match_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         data_req_o,
    output logic                         data_we_o,
    output logic [INDEX_W-1:0]           address_index_o,
    output logic [63:0]                  data_wdata_o,
    output logic [7:0]                   data_be_o,
    output logic [1:0]                   data_size_o,
    output logic [TAG_W-1:0]             address_tag_o,
    output logic                         tag_valid_o,
    output logic                         kill_req_o,
    input  logic                         data_gnt_i
);

    localparam int unsigned PA_W  = INDEX_W + TAG_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PA_W-1:0]    paddr_mem [DEPTH];
    logic [63:0]        data_mem  [DEPTH];
    logic [7:0]         be_mem    [DEPTH];
    logic [1:0]         size_mem  [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [DEPTH-1:0]   valid_q, valid_n;
    logic               tag_pending_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:3] tag_off_q;

    logic               push_fire, pop_fire;
    logic [PA_W-1:0]    head_paddr;

    assign push_ready_o = (count_q < CNT_W'(DEPTH));
    assign data_req_o   = (count_q != '0);
    assign push_fire    = push_valid_i && push_ready_o;
    assign pop_fire     = data_req_o && data_gnt_i;
    assign head_paddr   = paddr_mem[rd_ptr_q];

    // Pop clears before push sets; both can only hit the same slot when the
    // buffer is empty or full, and then one of them is blocked.
    always_comb begin
        valid_n = valid_q;
        if (pop_fire)  valid_n[rd_ptr_q] = 1'b0;
        if (push_fire) valid_n[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            tag_pending_q <= 1'b0;
            tag_q         <= '0;
            tag_off_q     <= '0;
        end else begin
            valid_q       <= valid_n;
            tag_pending_q <= pop_fire;
            if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_fire) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                tag_q     <= head_paddr[PA_W-1:INDEX_W];
                tag_off_q <= head_paddr[INDEX_W-1:3];
            end
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: every read is qualified by count or valid.
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            paddr_mem[wr_ptr_q] <= push_paddr_i;
            data_mem[wr_ptr_q]  <= push_data_i;
            be_mem[wr_ptr_q]    <= push_be_i;
            size_mem[wr_ptr_q]  <= push_size_i;
        end
    end

    always_comb begin
        page_offset_match_o = tag_pending_q && (tag_off_q == page_offset_i[INDEX_W-1:3]);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (paddr_mem[i][INDEX_W-1:3] == page_offset_i[INDEX_W-1:3]))
                page_offset_match_o = 1'b1;
        end
    end

    assign data_we_o       = 1'b1;
    assign kill_req_o      = 1'b0;
    assign address_index_o = data_req_o ? head_paddr[INDEX_W-1:0] : '0;
    assign data_wdata_o    = data_req_o ? data_mem[rd_ptr_q] : '0;
    assign data_be_o       = data_req_o ? be_mem[rd_ptr_q] : '0;
    assign data_size_o     = data_req_o ? size_mem[rd_ptr_q] : '0;
    assign address_tag_o   = tag_q;
    assign tag_valid_o     = tag_pending_q;
    assign empty_o         = (count_q == '0) && !tag_pending_q;
    assign count_o         = count_q;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: a negedge monitor keeps a queue of
// accepted stores and checks both dcache phases plus count/empty/match.
module tb_store_drain_buffer;

    localparam int EW = 130;   // {tag[43:0], idx[11:0], data[63:0], be[7:0], size[1:0]}

    logic        clk_i, rst_ni;
    logic        push_valid_i, push_ready_o;
    logic [55:0] push_paddr_i;
    logic [63:0] push_data_i;
    logic [7:0]  push_be_i;
    logic [1:0]  push_size_i;
    logic [11:0] page_offset_i;
    logic        page_offset_match_o, empty_o;
    logic [3:0]  count_o;
    logic        data_req_o, data_we_o, tag_valid_o, kill_req_o, data_gnt_i;
    logic [11:0] address_index_o;
    logic [63:0] data_wdata_o;
    logic [7:0]  data_be_o;
    logic [1:0]  data_size_o;
    logic [43:0] address_tag_o;

    store_drain_buffer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_paddr_i(push_paddr_i), .push_data_i(push_data_i),
        .push_be_i(push_be_i), .push_size_i(push_size_i),
        .page_offset_i(page_offset_i), .page_offset_match_o(page_offset_match_o),
        .empty_o(empty_o), .count_o(count_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o),
        .address_index_o(address_index_o), .data_wdata_o(data_wdata_o),
        .data_be_o(data_be_o), .data_size_o(data_size_o),
        .address_tag_o(address_tag_o), .tag_valid_o(tag_valid_o),
        .kill_req_o(kill_req_o), .data_gnt_i(data_gnt_i)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [55:0] pa, input logic [63:0] d,
                            input logic [7:0] be, input logic [1:0] sz);
        push_valid_i = v;
        push_paddr_i = pa;
        push_data_i  = d;
        push_be_i    = be;
        push_size_i  = sz;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            set_push(1'b1, {44'(base + i), 12'(16 * (base + i) + 8)},
                     64'(32'hA000_0000 + (base + i)), 8'(base + i), 2'(i));
            cyc();
        end
        set_push(1'b0, '0, '0, '0, '0);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        data_gnt_i = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk_i);
            if (empty_o) done = 1'b1;
            cyc();
        end
        chk("drain_empty", 64'(done), 64'd1);
        data_gnt_i = 1'b0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [EW-1:0] exp_q[$];
    logic          tag_exp = 1'b0;
    logic [43:0]   tag_exp_v = '0;
    logic [11:3]   tag_exp_off = '0;

    always @(negedge clk_i) begin
        logic [43:0] e_tag;
        logic [11:0] e_idx;
        logic [63:0] e_data;
        logic [7:0]  e_be;
        logic [1:0]  e_sz;
        logic        exp_match;
        if (!rst_ni) begin
            exp_q.delete();
            tag_exp = 1'b0;
            chk("rst_tag_valid", 64'(tag_valid_o), 64'd0);
            chk("rst_count", 64'(count_o), 64'd0);
            chk("rst_empty", 64'(empty_o), 64'd1);
        end else begin
            chk("count", 64'(count_o), 64'(exp_q.size()));
            chk("push_ready", 64'(push_ready_o), 64'(exp_q.size() < 8));
            chk("data_req", 64'(data_req_o), 64'(exp_q.size() > 0));
            chk("empty", 64'(empty_o), 64'(exp_q.size() == 0 && !tag_exp));
            chk("we_kill", 64'({data_we_o, kill_req_o}), 64'h2);
            exp_match = tag_exp && (tag_exp_off == page_offset_i[11:3]);
            for (int i = 0; i < exp_q.size(); i++) begin
                {e_tag, e_idx, e_data, e_be, e_sz} = exp_q[i];
                if (e_idx[11:3] == page_offset_i[11:3]) exp_match = 1'b1;
            end
            chk("match_model", 64'(page_offset_match_o), 64'(exp_match));
            chk("tag_valid", 64'(tag_valid_o), 64'(tag_exp));
            if (tag_exp) chk("address_tag", 64'(address_tag_o), 64'(tag_exp_v));
            tag_exp = 1'b0;
            if (data_req_o && data_gnt_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 64'd1, 64'd0);
                end else begin
                    {e_tag, e_idx, e_data, e_be, e_sz} = exp_q.pop_front();
                    chk("address_index", 64'(address_index_o), 64'(e_idx));
                    chk("wdata", data_wdata_o, e_data);
                    chk("be", 64'(data_be_o), 64'(e_be));
                    chk("size", 64'(data_size_o), 64'(e_sz));
                    tag_exp     = 1'b1;
                    tag_exp_v   = e_tag;
                    tag_exp_off = e_idx[11:3];
                end
            end
            if (push_valid_i && push_ready_o)
                exp_q.push_back({push_paddr_i[55:12], push_paddr_i[11:0],
                                 push_data_i, push_be_i, push_size_i});
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [5:0]  gp, tp;
        logic [63:0] r;
        int          pushed, maxc;
        logic        done;

        rst_ni = 1'b0;
        data_gnt_i = 1'b0;
        page_offset_i = '0;
        set_push(1'b0, '0, '0, '0, '0);
        repeat (3) cyc();
        @(negedge clk_i);
        chk("reset_push_ready", 64'(push_ready_o), 64'd1);
        chk("reset_data_req", 64'(data_req_o), 64'd0);
        chk("reset_match", 64'(page_offset_match_o), 64'd0);
        chk("reset_we_kill", 64'({data_we_o, kill_req_o}), 64'h2);
        chk("reset_bus", 64'({address_index_o, data_be_o, data_size_o} | address_tag_o | data_wdata_o), 64'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // single store, grant always high
        data_gnt_i = 1'b1;
        set_push(1'b1, 56'h8000_1238, 64'hDEAD_BEEF, 8'h0F, 2'd2);
        @(negedge clk_i);
        chk("s1_no_bypass", 64'(data_req_o), 64'd0);
        cyc();
        set_push(1'b0, '0, '0, '0, '0);
        @(negedge clk_i);
        chk("s1_req", 64'(data_req_o), 64'd1);
        chk("s1_index", 64'(address_index_o), 64'h238);
        cyc();
        @(negedge clk_i);
        chk("s1_tag_valid", 64'(tag_valid_o), 64'd1);
        chk("s1_tag", 64'(address_tag_o), 64'h80001);
        cyc();
        @(negedge clk_i);
        chk("s1_empty", 64'(empty_o), 64'd1);
        cyc();

        // fill to full, refusal, push alongside a grant
        data_gnt_i = 1'b0;
        push_n(8, 16);
        set_push(1'b1, 56'h00ABC_0F0, 64'h9999, 8'hFF, 2'd3);
        @(negedge clk_i);
        chk("full_ready", 64'(push_ready_o), 64'd0);
        chk("full_count", 64'(count_o), 64'd8);
        cyc();
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("full_ready_with_grant", 64'(push_ready_o), 64'd0);
        cyc();
        data_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("after_grant_ready", 64'(push_ready_o), 64'd1);
        chk("after_grant_count", 64'(count_o), 64'd7);
        cyc();
        set_push(1'b0, '0, '0, '0, '0);
        drain();

        // back-to-back grants
        push_n(4, 32);
        data_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            gp[k] = data_req_o && data_gnt_i;
            tp[k] = tag_valid_o;
            cyc();
        end
        chk("b2b_grants", 64'(gp), 64'h0F);
        chk("b2b_tags", 64'(tp), 64'h1E);
        data_gnt_i = 1'b0;

        // page offset hazard
        set_push(1'b1, 56'h12345_238, 64'h1234, 8'hF0, 2'd1);
        cyc();
        set_push(1'b0, '0, '0, '0, '0);
        page_offset_i = 12'h23C;
        @(negedge clk_i);
        chk("match_23c", 64'(page_offset_match_o), 64'd1);
        cyc();
        page_offset_i = 12'h240;
        @(negedge clk_i);
        chk("match_240", 64'(page_offset_match_o), 64'd0);
        cyc();
        page_offset_i = 12'h23C;
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("match_grant", 64'(page_offset_match_o), 64'd1);
        cyc();
        data_gnt_i = 1'b0;
        @(negedge clk_i);
        chk("match_tag_cycle", 64'(page_offset_match_o), 64'd1);
        cyc();
        @(negedge clk_i);
        chk("match_cleared", 64'(page_offset_match_o), 64'd0);
        cyc();
        page_offset_i = '0;

        // reset right after a grant
        push_n(2, 48);
        data_gnt_i = 1'b1;
        cyc();
        data_gnt_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("midrst_tag_valid", 64'(tag_valid_o), 64'd0);
        chk("midrst_count", 64'(count_o), 64'd0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        @(negedge clk_i);
        chk("postrst_count", 64'(count_o), 64'd0);
        chk("postrst_empty", 64'(empty_o), 64'd1);
        cyc();

        // wrap-around with random grants
        pushed = 0;
        maxc = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (pushed < 20) begin
                r = {$urandom(), $urandom()};
                set_push(1'b1, r[55:0], {r[31:0], r[63:32]}, r[7:0], r[9:8]);
            end else begin
                set_push(1'b0, '0, '0, '0, '0);
            end
            data_gnt_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            if (push_valid_i && push_ready_o) pushed++;
            if (int'(count_o) > maxc) maxc = int'(count_o);
            if (!push_valid_i && pushed == 20 && empty_o) done = 1'b1;
            cyc();
        end
        set_push(1'b0, '0, '0, '0, '0);
        data_gnt_i = 1'b0;
        chk("wrap_done", 64'(done), 64'd1);
        chk("wrap_max_count_ok", 64'(maxc <= 8), 64'd1);
        chk("wrap_queue_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
